// File: rtl/spi_ram_ctrl_pkg.sv
// +----------------------------------------------------------------------+
// | spi_ram_pkg: command codes and SPI word width for the SPI RAM stage  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

package spi_ram_pkg;

    localparam int SPI_WORD_W = 10;

    localparam logic [1:0] CMD_WR_ADDR = 2'b00;
    localparam logic [1:0] CMD_WR_DATA = 2'b01;
    localparam logic [1:0] CMD_RD_ADDR = 2'b10;
    localparam logic [1:0] CMD_RD_DATA = 2'b11;

endpackage

`default_nettype wire

// File: rtl/spi_ram_ctrl_if.sv
// +----------------------------------------------------------------------+
// | spi_ram_if: SPI slave <-> RAM stage word interface                   |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

interface spi_ram_if;
    import spi_ram_pkg::*;

    logic [SPI_WORD_W-1:0] rx_data;
    logic                  rx_valid;
    logic [7:0]            tx_data;
    logic                  tx_valid;

    // master is the SPI slave side, slave is the RAM stage
    modport master (output rx_data, output rx_valid, input tx_data, input tx_valid);
    modport slave  (input rx_data, input rx_valid, output tx_data, output tx_valid);

endinterface

`default_nettype wire

// File: rtl/spi_ram_ctrl_mem.sv
// +----------------------------------------------------------------------+
// | spi_ram_mem: 8-bit storage array, synchronous write, registered read |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

module spi_ram_mem #(
    parameter int DEPTH  = 256,
    parameter int ADDR_W = 8
) (
    input  wire logic              clk,
    input  wire logic              we,
    input  wire logic [ADDR_W-1:0] addr,
    input  wire logic [7:0]        wdata,
    output logic      [7:0]        rdata
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [7:0]       mem [DEPTH];
    logic [IDX_W-1:0] idx;

    assign idx = addr[IDX_W-1:0];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[idx] <= wdata;
        end
        rdata <= mem[idx];
    end

endmodule

`default_nettype wire

// File: rtl/spi_ram_ctrl.sv
// +----------------------------------------------------------------------+
// | spi_ram_ctrl: decodes SPI command words into RAM writes and reads    |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

module spi_ram_ctrl
    import spi_ram_pkg::*;
#(
    parameter int MEM_DEPTH = 256,
    parameter int ADDR_SIZE = 8,
    parameter bit AUTO_INC  = 1'b0
) (
    input  wire logic  clk,
    input  wire logic  rst_n,
    spi_ram_if.slave   bus
);

    localparam logic [ADDR_SIZE:0] DEPTH_W = (ADDR_SIZE+1)'(MEM_DEPTH);
    localparam logic [ADDR_SIZE:0] LAST_W  = (ADDR_SIZE+1)'(MEM_DEPTH - 1);

    logic [1:0]           w_cmd;
    logic                 w_wr;
    logic                 w_rd;
    logic                 w_mem_we;
    logic [ADDR_SIZE-1:0] w_mem_addr;
    logic [7:0]           w_mem_rdata;
    logic [7:0]           w_rd_word;

    logic [ADDR_SIZE-1:0] r_wr_addr;
    logic [ADDR_SIZE-1:0] r_rd_addr;
    logic                 r_tx_valid;
    logic                 r_rd_oor;
    logic [7:0]           r_tx_hold;

    function automatic logic in_range(input logic [ADDR_SIZE-1:0] a);
        return ({1'b0, a} < DEPTH_W);
    endfunction

    function automatic logic [ADDR_SIZE-1:0] next_addr(input logic [ADDR_SIZE-1:0] a);
        if ({1'b0, a} == LAST_W) begin
            return '0;
        end
        return a + ADDR_SIZE'(1);
    endfunction

    assign w_cmd      = bus.rx_data[9:8];
    assign w_wr       = bus.rx_valid && (w_cmd == CMD_WR_DATA);
    assign w_rd       = bus.rx_valid && (w_cmd == CMD_RD_DATA);
    assign w_mem_we   = w_wr && in_range(r_wr_addr);
    assign w_mem_addr = w_rd ? r_rd_addr : r_wr_addr;

    spi_ram_mem #(
        .DEPTH  (MEM_DEPTH),
        .ADDR_W (ADDR_SIZE)
    ) u_mem (
        .clk   (clk),
        .we    (w_mem_we),
        .addr  (w_mem_addr),
        .wdata (bus.rx_data[7:0]),
        .rdata (w_mem_rdata)
    );

    // The array output changes every cycle, so the last read is parked in
    // r_tx_hold once its strobe cycle has passed.
    assign w_rd_word   = r_rd_oor ? 8'h00 : w_mem_rdata;
    assign bus.tx_data = r_tx_valid ? w_rd_word : r_tx_hold;
    assign bus.tx_valid = r_tx_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_addr  <= '0;
            r_rd_addr  <= '0;
            r_tx_valid <= 1'b0;
            r_rd_oor   <= 1'b0;
            r_tx_hold  <= 8'h00;
        end else begin
            r_tx_valid <= w_rd;
            if (r_tx_valid) begin
                r_tx_hold <= w_rd_word;
            end
            if (bus.rx_valid) begin
                case (w_cmd)
                    CMD_WR_ADDR: r_wr_addr <= bus.rx_data[ADDR_SIZE-1:0];
                    CMD_WR_DATA: if (AUTO_INC) r_wr_addr <= next_addr(r_wr_addr);
                    CMD_RD_ADDR: r_rd_addr <= bus.rx_data[ADDR_SIZE-1:0];
                    default: begin
                        r_rd_oor <= !in_range(r_rd_addr);
                        if (AUTO_INC) r_rd_addr <= next_addr(r_rd_addr);
                    end
                endcase
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_spi_ram_ctrl.sv
// +----------------------------------------------------------------------+
// | tb_spi_ram_ctrl: two configurations driven in lockstep vs. a model   |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_spi_ram_ctrl;
    import spi_ram_pkg::*;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    spi_ram_if bus_a ();
    spi_ram_if bus_b ();

    // a: full depth with auto-increment; b: non-power-of-2 depth, no increment
    spi_ram_ctrl #(.MEM_DEPTH(256), .ADDR_SIZE(8), .AUTO_INC(1'b1)) dut_a (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_a.slave)
    );
    spi_ram_ctrl #(.MEM_DEPTH(200), .ADDR_SIZE(8), .AUTO_INC(1'b0)) dut_b (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_b.slave)
    );

    int         depth [2] = '{256, 200};
    bit         ainc  [2] = '{1'b1, 1'b0};
    logic [7:0] m_mem [2][256];
    logic [7:0] m_wr  [2];
    logic [7:0] m_rd  [2];
    logic [7:0] m_tx  [2];
    logic       m_txv [2];

    function automatic logic [7:0] bump(input int d, input logic [7:0] a);
        return (int'(a) == d - 1) ? 8'h00 : a + 8'h01;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_wr[k] = 8'h00; m_rd[k] = 8'h00; m_tx[k] = 8'h00; m_txv[k] = 1'b0;
        end
    endtask

    task automatic model_step(input logic v, input logic [9:0] w);
        for (int k = 0; k < 2; k++) begin
            m_txv[k] = 1'b0;
            if (v) begin
                case (w[9:8])
                    CMD_WR_ADDR: m_wr[k] = w[7:0];
                    CMD_WR_DATA: begin
                        if (int'(m_wr[k]) < depth[k]) m_mem[k][m_wr[k]] = w[7:0];
                        if (ainc[k]) m_wr[k] = bump(depth[k], m_wr[k]);
                    end
                    CMD_RD_ADDR: m_rd[k] = w[7:0];
                    default: begin
                        m_tx[k]  = (int'(m_rd[k]) < depth[k]) ? m_mem[k][m_rd[k]] : 8'h00;
                        m_txv[k] = 1'b1;
                        if (ainc[k]) m_rd[k] = bump(depth[k], m_rd[k]);
                    end
                endcase
            end
        end
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%02h expected=%02h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs();
        chk("a_tx_valid", {7'b0, bus_a.tx_valid}, {7'b0, m_txv[0]});
        chk("a_tx_data",  bus_a.tx_data, m_tx[0]);
        chk("b_tx_valid", {7'b0, bus_b.tx_valid}, {7'b0, m_txv[1]});
        chk("b_tx_data",  bus_b.tx_data, m_tx[1]);
    endtask

    task automatic drive(input logic v, input logic [9:0] w);
        bus_a.rx_valid = v; bus_a.rx_data = w;
        bus_b.rx_valid = v; bus_b.rx_data = w;
    endtask

    task automatic op(input logic v, input logic [9:0] w);
        @(negedge clk);
        drive(v, w);
        @(posedge clk);
        model_step(v, w);
        #1;
        check_outputs();
    endtask

    initial begin
        logic [7:0] ia;
        logic       rv;
        drive(1'b0, 10'h000);
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check_outputs();
        @(negedge clk);
        rst_n = 1'b1;

        // fill every address so all later reads have defined data
        for (int i = 0; i < 256; i++) begin
            ia = i[7:0];
            op(1'b1, {CMD_WR_ADDR, ia});
            op(1'b1, {CMD_WR_DATA, 8'($urandom)});
        end

        // reset asserted between edges clears outputs at once
        op(1'b1, {CMD_RD_ADDR, 8'h33});
        op(1'b1, {CMD_RD_DATA, 8'h00});
        #2;
        rst_n = 1'b0;
        drive(1'b0, 10'h000);
        #1;
        model_reset();
        check_outputs();
        @(negedge clk);
        rst_n = 1'b1;

        // write then read one location
        op(1'b1, 10'h02A);
        op(1'b1, 10'h15C);
        op(1'b1, 10'h22A);
        op(1'b1, 10'h300);
        chk("t2_a_data", bus_a.tx_data, 8'h5C);
        chk("t2_b_data", bus_b.tx_data, 8'h5C);
        op(1'b0, 10'h000);

        // auto-increment wrap and back-to-back reads
        op(1'b1, {CMD_WR_ADDR, 8'hFF});
        op(1'b1, {CMD_WR_DATA, 8'hA5});
        op(1'b1, {CMD_WR_DATA, 8'hB6});
        op(1'b1, {CMD_RD_ADDR, 8'hFF});
        op(1'b1, {CMD_RD_DATA, 8'h00});
        chk("t3_first", bus_a.tx_data, 8'hA5);
        op(1'b1, {CMD_RD_DATA, 8'h00});
        chk("t3_second", bus_a.tx_data, 8'hB6);
        chk("t3_valid", {7'b0, bus_a.tx_valid}, 8'h01);
        op(1'b0, 10'h000);

        // out-of-range address on the 200-deep instance
        op(1'b1, {CMD_WR_ADDR, 8'd210});
        op(1'b1, {CMD_WR_DATA, 8'h77});
        op(1'b1, {CMD_RD_ADDR, 8'd210});
        op(1'b1, {CMD_RD_DATA, 8'h00});
        chk("t5_oor_read", bus_b.tx_data, 8'h00);
        op(1'b1, {CMD_RD_ADDR, 8'd10});
        op(1'b1, {CMD_RD_DATA, 8'h00});

        // random ops with idle gaps
        for (int i = 0; i < 400; i++) begin
            rv = ($urandom_range(0, 2) != 0);
            op(rv, 10'($urandom));
        end

        // reset held across the edge that samples a read
        @(negedge clk);
        drive(1'b1, {CMD_RD_DATA, 8'h00});
        #4;
        rst_n = 1'b0;
        @(posedge clk);
        model_reset();
        #1;
        check_outputs();
        @(negedge clk);
        drive(1'b0, 10'h000);
        rst_n = 1'b1;
        op(1'b1, {CMD_RD_DATA, 8'h00});
        op(1'b1, {CMD_WR_DATA, 8'h9E});
        op(1'b1, {CMD_RD_ADDR, 8'h00});
        op(1'b1, {CMD_RD_DATA, 8'h00});
        chk("t6_a_addr0", bus_a.tx_data, 8'h9E);
        chk("t6_b_addr0", bus_b.tx_data, 8'h9E);
        op(1'b0, 10'h000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
